// File: rtl/mips_dbg_pkg.sv
// rtl/mips_dbg_pkg.sv - shared state encoding and dump beat kinds for the run monitor
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_DUMP_REG = 3'd2,
    ST_DUMP_MEM = 3'd3,
    ST_DONE     = 3'd4
  } mon_state_t;

  localparam logic [1:0] DUMP_KIND_TRACE = 2'b00;
  localparam logic [1:0] DUMP_KIND_REG   = 2'b01;
  localparam logic [1:0] DUMP_KIND_MEM   = 2'b10;

endpackage

// File: rtl/mips_dump_seq.sv
// rtl/mips_dump_seq.sv - walk index for the register and memory dump phases
module mips_dump_seq
  import mips_dbg_pkg::*;
#(
  parameter int IDX_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [IDX_W-1:0] last_index,
  output logic [IDX_W-1:0] index,
  output logic             at_last
);

  // Clear outranks advance so the final beat of one walk can restart the next at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      index <= '0;
    end else if (clear) begin
      index <= '0;
    end else if (advance) begin
      index <= index + 1'b1;
    end
  end

  assign at_last = (index == last_index);

endmodule

// File: rtl/mips_run_monitor.sv
// rtl/mips_run_monitor.sv - CPU run gate, trace streamer and end-of-run state dumper
module mips_run_monitor
  import mips_dbg_pkg::*;
#(
  parameter int          MAX_CYCLES  = 30,
  parameter bit          USE_HALT_PC = 1'b0,
  parameter logic [31:0] HALT_PC     = 32'h0000_3FFC,
  parameter bit          TRACE_EN    = 1'b1,
  parameter int          NUM_REGS    = 32,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0050,
  parameter int          MEM_WORDS   = 2,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      pc,
  input  logic [31:0]      instr,
  output logic             cpu_stall,
  output logic [4:0]       rf_raddr,
  input  logic [31:0]      rf_rdata,
  output logic [29:0]      dm_raddr,
  input  logic [31:0]      dm_rdata,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [1:0]       dump_kind,
  output logic [31:0]      dump_addr,
  output logic [31:0]      dump_data,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [31:0]      REG_LAST  = 32'(NUM_REGS - 1);
  localparam logic [31:0]      MEM_LAST  = (MEM_WORDS > 0) ? 32'(MEM_WORDS - 1) : 32'd0;
  localparam logic [29:0]      MEM_WBASE = MEM_BASE[31:2];
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  mon_state_t       state, state_next;
  logic [31:0]      index;
  logic             at_last;
  logic [31:0]      seq_last;
  logic             seq_clear, seq_advance;
  logic             retire, run_start, done_set, beat;
  logic [CNT_W-1:0] count_inc;

  mips_dump_seq #(.IDX_W(32)) u_seq (
    .clk        (clk),
    .rst        (rst),
    .clear      (seq_clear),
    .advance    (seq_advance),
    .last_index (seq_last),
    .index      (index),
    .at_last    (at_last)
  );

  assign count_inc = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + 1'b1;
  assign beat      = dump_valid & dump_ready;

  // Next state and all stream/stall outputs; outputs depend only on state, index and inputs.
  always_comb begin
    state_next  = state;
    cpu_stall   = 1'b1;
    dump_valid  = 1'b0;
    dump_kind   = DUMP_KIND_TRACE;
    dump_addr   = '0;
    dump_data   = '0;
    rf_raddr    = '0;
    dm_raddr    = '0;
    retire      = 1'b0;
    run_start   = 1'b0;
    done_set    = 1'b0;
    seq_clear   = 1'b0;
    seq_advance = 1'b0;
    seq_last    = REG_LAST;
    case (state)
      ST_IDLE, ST_DONE: begin
        seq_clear = 1'b1;
        if (start) begin
          state_next = ST_RUN;
          run_start  = 1'b1;
        end
      end
      ST_RUN: begin
        seq_clear = 1'b1;
        if (USE_HALT_PC && (pc == HALT_PC)) begin
          // The halt instruction itself is never traced or executed.
          state_next = ST_DUMP_REG;
        end else begin
          if (TRACE_EN) begin
            dump_valid = 1'b1;
            dump_kind  = DUMP_KIND_TRACE;
            dump_addr  = pc;
            dump_data  = instr;
            cpu_stall  = ~dump_ready;
          end else begin
            cpu_stall  = 1'b0;
          end
          retire = ~cpu_stall;
          if (retire && (32'(count_inc) == MAX_CYCLES)) begin
            state_next = ST_DUMP_REG;
          end
        end
      end
      ST_DUMP_REG: begin
        dump_valid  = 1'b1;
        dump_kind   = DUMP_KIND_REG;
        dump_addr   = index;
        rf_raddr    = index[4:0];
        dump_data   = (index == 32'd0) ? 32'd0 : rf_rdata;
        seq_last    = REG_LAST;
        seq_advance = beat;
        if (beat && at_last) begin
          seq_clear = 1'b1;
          if (MEM_WORDS == 0) begin
            state_next = ST_DONE;
            done_set   = 1'b1;
          end else begin
            state_next = ST_DUMP_MEM;
          end
        end
      end
      ST_DUMP_MEM: begin
        dump_valid  = 1'b1;
        dump_kind   = DUMP_KIND_MEM;
        dump_addr   = MEM_BASE + {index[29:0], 2'b00};
        dm_raddr    = MEM_WBASE + index[29:0];
        dump_data   = dm_rdata;
        seq_last    = MEM_LAST;
        seq_advance = beat;
        if (beat && at_last) begin
          state_next = ST_DONE;
          done_set   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, saturating retirement counter and sticky done flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cycle_count <= '0;
      done        <= 1'b0;
    end else begin
      state <= state_next;
      if (run_start) begin
        cycle_count <= '0;
      end else if (retire) begin
        cycle_count <= count_inc;
      end
      if (run_start) begin
        done <= 1'b0;
      end else if (done_set) begin
        done <= 1'b1;
      end
    end
  end

endmodule
